input_debounce: RTL and testbench

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/input_debounce_if.sv | 44 ++++
 rtl/input_debounce.sv | 117 +++++++++++
 tb/tb_input_debounce.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/input_debounce_if.sv
// Raw pushbutton/switch inputs and debounced outputs of input_debounce.
// Edge-pulse signals exist only when INPUT_DEBOUNCE_EDGE_PULSE_EN is defined.
interface input_debounce_if;
  logic [1:0] KEY;
  logic [1:0] SW;
  logic [1:0] KEY_db;
  logic [1:0] SW_db;
`ifdef INPUT_DEBOUNCE_EDGE_PULSE_EN
  logic [1:0] KEY_press;
  logic [1:0] SW_rise;

  modport master (
    output KEY,
    output SW,
    input  KEY_db,
    input  SW_db,
    input  KEY_press,
    input  SW_rise
  );

  modport slave (
    input  KEY,
    input  SW,
    output KEY_db,
    output SW_db,
    output KEY_press,
    output SW_rise
  );
`else
  modport master (
    output KEY,
    output SW,
    input  KEY_db,
    input  SW_db
  );

  modport slave (
    input  KEY,
    input  SW,
    output KEY_db,
    output SW_db
  );
`endif
endinterface

// File: rtl/input_debounce.sv
// Four independent debounce channels: 2 active-low pushbuttons and 2 slide switches.
// Optional one-cycle edge pulses (KEY_press, SW_rise) under INPUT_DEBOUNCE_EDGE_PULSE_EN.
module input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  input_debounce_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  // Channel order {SW[1], SW[0], KEY[1], KEY[0]}; keys idle high, switches idle low.
  localparam logic [3:0] RST_VAL = 4'b0011;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_t;

  logic [3:0]       raw_s;
  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [3:0]       db_r;
  logic [3:0]       db_next_s;
  state_t           state_r      [4];
  state_t           state_next_s [4];
  logic [CNT_W-1:0] cnt_r        [4];
  logic [CNT_W-1:0] cnt_next_s   [4];

  assign raw_s = {bus.SW, bus.KEY};

  // Synchronizers, debounced levels, per-channel FSM state and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r <= RST_VAL;
      sync2_r <= RST_VAL;
      db_r    <= RST_VAL;
      for (int i = 0; i < 4; i++) begin
        state_r[i] <= STABLE;
        cnt_r[i]   <= CNT_ZERO;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      db_r    <= db_next_s;
      for (int i = 0; i < 4; i++) begin
        state_r[i] <= state_next_s[i];
        cnt_r[i]   <= cnt_next_s[i];
      end
    end
  end

  // Next-state: a sample equal to the output aborts the count; a full run commits it.
  always_comb begin
    db_next_s = db_r;
    for (int i = 0; i < 4; i++) begin
      state_next_s[i] = state_r[i];
      cnt_next_s[i]   = cnt_r[i];
      case (state_r[i])
        STABLE: begin
          if (sync2_r[i] != db_r[i]) begin
            state_next_s[i] = COUNTING;
            cnt_next_s[i]   = CNT_ONE;
          end else begin
            cnt_next_s[i]   = CNT_ZERO;
          end
        end
        COUNTING: begin
          if (sync2_r[i] == db_r[i]) begin
            state_next_s[i] = STABLE;
            cnt_next_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] < CNT_LAST) begin
            cnt_next_s[i]   = cnt_r[i] + CNT_ONE;
          end else begin
            db_next_s[i]    = sync2_r[i];
            state_next_s[i] = STABLE;
            cnt_next_s[i]   = CNT_ZERO;
          end
        end
        default: begin
          state_next_s[i] = STABLE;
          cnt_next_s[i]   = CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.KEY_db = db_r[1:0];
  assign bus.SW_db  = db_r[3:2];

`ifdef INPUT_DEBOUNCE_EDGE_PULSE_EN
  logic [1:0] key_fall_s;
  logic [1:0] sw_rise_s;
  logic [1:0] key_press_r;
  logic [1:0] sw_rise_r;

  assign key_fall_s = db_r[1:0] & ~db_next_s[1:0];
  assign sw_rise_s  = ~db_r[3:2] & db_next_s[3:2];

  // Pulses are registered on the same edge the debounced level commits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_press_r <= 2'b00;
      sw_rise_r   <= 2'b00;
    end else begin
      key_press_r <= key_fall_s;
      sw_rise_r   <= sw_rise_s;
    end
  end

  assign bus.KEY_press = key_press_r;
  assign bus.SW_rise   = sw_rise_r;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: directed table, hand-written corner
// sequences, and randomized inputs against a sliding-window reference model.
module tb_input_debounce;
  localparam int DC = 4;

`ifdef INPUT_DEBOUNCE_EDGE_PULSE_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] CMP_MASK = 8'h0F;
`endif

  logic clk;
  logic rst;
  input_debounce_if bus ();

  input_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [1:0] key;
    logic [1:0] sw;
    logic [1:0] key_db;
    logic [1:0] sw_db;
    logic [1:0] press;
    logic [1:0] rise;
  } vec_t;

  vec_t tbl[$];

  // Reference model: 2-edge sync delay line, then a window of the last DC samples.
  logic [3:0] m_pipe1;
  logic [3:0] m_pipe2;
  logic [3:0] m_out;
  logic [1:0] m_press;
  logic [1:0] m_rise;
  bit         m_hist [4][$];

  task automatic model_step(input logic r, input logic [3:0] raw);
    logic smp;
    bit   all_diff;
    m_press = 2'b00;
    m_rise  = 2'b00;
    if (!r) begin
      m_out   = 4'b0011;
      m_pipe1 = 4'b0011;
      m_pipe2 = 4'b0011;
      for (int ch = 0; ch < 4; ch++) m_hist[ch].delete();
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        smp         = m_pipe2[ch];
        m_pipe2[ch] = m_pipe1[ch];
        m_pipe1[ch] = raw[ch];
        m_hist[ch].push_back(smp);
        if (m_hist[ch].size() > DC) void'(m_hist[ch].pop_front());
        all_diff = (m_hist[ch].size() == DC);
        for (int j = 0; j < m_hist[ch].size(); j++)
          if (m_hist[ch][j] == m_out[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_out[ch] = ~m_out[ch];
          if (ch < 2 && !m_out[ch]) m_press[ch] = 1'b1;
          if (ch >= 2 && m_out[ch]) m_rise[ch-2] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic [1:0] k, input logic [1:0] s);
    rst     = r;
    bus.KEY = k;
    bus.SW  = s;
    @(posedge clk);
    model_step(r, {s, k});
    #1;
  endtask

  function automatic logic [7:0] observe();
`ifdef INPUT_DEBOUNCE_EDGE_PULSE_EN
    return {bus.SW_rise, bus.KEY_press, bus.SW_db, bus.KEY_db};
`else
    return {4'h0, bus.SW_db, bus.KEY_db};
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] exp_v);
    logic [7:0] got_v;
    got_v  = observe();
    checks = checks + 1;
    if ((got_v & CMP_MASK) !== (exp_v & CMP_MASK)) begin
      errors = errors + 1;
      $display("FAIL %s: got {rise,press,sw_db,key_db}=%b expected %b",
               name, got_v & CMP_MASK, exp_v & CMP_MASK);
    end
  endtask

  task automatic add_n(input int n, input logic r, input logic [1:0] k, input logic [1:0] s,
                       input logic [1:0] kd, input logic [1:0] sd,
                       input logic [1:0] p, input logic [1:0] rs);
    for (int i = 0; i < n; i++) tbl.push_back('{r, k, s, kd, sd, p, rs});
  endtask

  initial begin
    logic [3:0] rnd_raw;
    logic       rnd_rst;

    rst     = 1'b0;
    bus.KEY = 2'b11;
    bus.SW  = 2'b00;

    // Reset with inverted raw inputs, clean KEY[0] press, KEY[1] glitch, KEY[0] release.
    add_n(3, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    add_n(1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    add_n(5, 1'b1, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    add_n(1, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00);
    add_n(1, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add_n(3, 1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add_n(6, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add_n(5, 1'b1, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add_n(2, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].key, tbl[i].sw);
      check($sformatf("vec%0d", i), {tbl[i].rise, tbl[i].press, tbl[i].sw_db, tbl[i].key_db});
    end

    // SW[1] bounce 1,1,0,0 then held high: rises on the 6th edge after the last change.
    tick(1'b1, 2'b11, 2'b10); check("bounce_a", {2'b00, 2'b00, 2'b00, 2'b11});
    tick(1'b1, 2'b11, 2'b10); check("bounce_b", {2'b00, 2'b00, 2'b00, 2'b11});
    tick(1'b1, 2'b11, 2'b00); check("bounce_c", {2'b00, 2'b00, 2'b00, 2'b11});
    tick(1'b1, 2'b11, 2'b00); check("bounce_d", {2'b00, 2'b00, 2'b00, 2'b11});
    for (int e = 1; e <= 8; e++) begin
      tick(1'b1, 2'b11, 2'b10);
      check($sformatf("bounce_hold_e%0d", e),
            {(e == 6) ? 2'b10 : 2'b00, 2'b00, (e >= 6) ? 2'b10 : 2'b00, 2'b11});
    end

    // SW[0] rising, reset on the 4th edge, then both switches re-debounce after release.
    for (int e = 1; e <= 3; e++) begin
      tick(1'b1, 2'b11, 2'b11);
      check($sformatf("midrst_pre_e%0d", e), {2'b00, 2'b00, 2'b10, 2'b11});
    end
    tick(1'b0, 2'b11, 2'b11); check("midrst_reset", {2'b00, 2'b00, 2'b00, 2'b11});
    for (int e = 5; e <= 11; e++) begin
      tick(1'b1, 2'b11, 2'b11);
      check($sformatf("midrst_post_e%0d", e),
            {(e == 10) ? 2'b11 : 2'b00, 2'b00, (e >= 10) ? 2'b11 : 2'b00, 2'b11});
    end

    // All four channels change together.
    tick(1'b0, 2'b11, 2'b00); check("simul_rst0", {2'b00, 2'b00, 2'b00, 2'b11});
    tick(1'b0, 2'b11, 2'b00); check("simul_rst1", {2'b00, 2'b00, 2'b00, 2'b11});
    tick(1'b1, 2'b11, 2'b00); check("simul_idle", {2'b00, 2'b00, 2'b00, 2'b11});
    for (int e = 1; e <= 7; e++) begin
      tick(1'b1, 2'b00, 2'b11);
      if (e < 6)       check($sformatf("simul_e%0d", e), {2'b00, 2'b00, 2'b00, 2'b11});
      else if (e == 6) check("simul_e6", {2'b11, 2'b11, 2'b11, 2'b00});
      else             check("simul_e7", {2'b00, 2'b00, 2'b11, 2'b00});
    end

    // Randomized inputs with occasional resets, checked against the model every edge.
    tick(1'b0, 2'b11, 2'b00);
    tick(1'b0, 2'b11, 2'b00);
    rnd_raw = 4'b0011;
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(0, 5) == 0) rnd_raw[ch] = ~rnd_raw[ch];
      rnd_rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick(rnd_rst, rnd_raw[1:0], rnd_raw[3:2]);
      check($sformatf("rand%0d", n), {m_rise, m_press, m_out});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
